// File: rtl/pg_precompute_stage.sv
// Bitwise generate/propagate precompute stage for a parallel-prefix adder.
// A 2-entry in-order skid buffer decouples the operand handshake from the prefix tree.
module pg_precompute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   G,
  output logic [WIDTH:0]   P,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [WIDTH:0] gen_w;
  logic [WIDTH:0] prop_w;

  logic [WIDTH:0] head_g_q, head_g_d;
  logic [WIDTH:0] head_p_q, head_p_d;
  logic [WIDTH:0] tail_g_q, tail_g_d;
  logic [WIDTH:0] tail_p_q, tail_p_d;
  logic [1:0]     occ_q, occ_d;

  logic accept;
  logic release_w;

  // Position 0 carries cin into the tree as a pure generate.
  assign gen_w[0]  = cin;
  assign prop_w[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_pg
      assign gen_w[gi+1]  = a[gi] & b[gi];
      assign prop_w[gi+1] = a[gi] ^ b[gi];
    end
  endgenerate

  // Handshake flags depend only on registered occupancy, never on out_ready.
  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready;
  assign release_w = out_valid && out_ready;

  always_comb begin
    head_g_d = head_g_q;
    head_p_d = head_p_q;
    tail_g_d = tail_g_q;
    tail_p_d = tail_p_q;
    occ_d    = occ_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          head_g_d = gen_w;
          head_p_d = prop_w;
          occ_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && release_w) begin
          head_g_d = gen_w;
          head_p_d = prop_w;
        end else if (accept) begin
          tail_g_d = gen_w;
          tail_p_d = prop_w;
          occ_d    = OCC_FULL;
        end else if (release_w) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (release_w) begin
          head_g_d = tail_g_q;
          head_p_d = tail_p_q;
          occ_d    = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_g_q <= '0;
      head_p_q <= '0;
      tail_g_q <= '0;
      tail_p_q <= '0;
      occ_q    <= OCC_EMPTY;
    end else begin
      head_g_q <= head_g_d;
      head_p_q <= head_p_d;
      tail_g_q <= tail_g_d;
      tail_p_q <= tail_p_d;
      occ_q    <= occ_d;
    end
  end

  assign G         = head_g_q;
  assign P         = head_p_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pg_precompute_stage.sv
// Directed bench for pg_precompute_stage at WIDTH=8, plus a short scoreboarded
// random valid/ready run.
module tb_pg_precompute_stage;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   g;
  logic [W:0]   p;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   occupancy;

  int n_checks;
  int n_fail;

  pg_precompute_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .G         (g),
    .P         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
  endtask

  function automatic logic [W:0] exp_g(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    return {av & bv, cv};
  endfunction

  function automatic logic [W:0] exp_p(input logic [W-1:0] av, input logic [W-1:0] bv);
    return {av ^ bv, 1'b0};
  endfunction

  logic [W-1:0] xa [6];
  logic [W-1:0] xb [6];
  logic         xc [6];

  typedef struct packed {
    logic [W:0] gv;
    logic [W:0] pv;
  } gp_t;

  gp_t sb_q[$];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    #1 rst = 1'b1;
    #2;
    check_eq("rst_occ",      32'(occupancy), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready),  32'd1);
    check_eq("rst_g",        32'(g),         32'd0);
    check_eq("rst_p",        32'(p),         32'd0);
    step();
    step();
    rst = 1'b0;

    // Single transaction, 1-cycle latency
    out_ready = 1'b1;
    offer(8'h5A, 8'h3C, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("lat_out_valid", 32'(out_valid), 32'd1);
    check_eq("lat_g", 32'(g), 32'h031);
    check_eq("lat_p", 32'(p), 32'h0CC);
    check_eq("lat_occ", 32'(occupancy), 32'd1);
    step();
    check_eq("lat_drain_valid", 32'(out_valid), 32'd0);
    check_eq("lat_drain_occ", 32'(occupancy), 32'd0);
    $display("txn: single a=5A b=3C cin=1 done");

    // Back-to-back offers against a stalled consumer
    out_ready = 1'b0;
    offer(8'h0F, 8'hF0, 1'b0);
    step();
    check_eq("bp_occ1", 32'(occupancy), 32'd1);
    check_eq("bp_in_ready1", 32'(in_ready), 32'd1);
    offer(8'hAA, 8'hAA, 1'b1);
    step();
    check_eq("bp_occ2", 32'(occupancy), 32'd2);
    check_eq("bp_in_ready2", 32'(in_ready), 32'd0);
    offer(8'h81, 8'h03, 1'b1);
    step();
    check_eq("bp_hold_occ", 32'(occupancy), 32'd2);
    check_eq("bp_hold_g", 32'(g), 32'h000);
    check_eq("bp_hold_p", 32'(p), 32'h1FE);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_indep", 32'(in_ready), 32'd0);
    step();
    check_eq("bp_t2_occ", 32'(occupancy), 32'd1);
    check_eq("bp_t2_g", 32'(g), 32'h155);
    check_eq("bp_t2_p", 32'(p), 32'h000);
    step();
    in_valid = 1'b0;
    check_eq("bp_t3_occ", 32'(occupancy), 32'd1);
    check_eq("bp_t3_g", 32'(g), 32'h003);
    check_eq("bp_t3_p", 32'(p), 32'h104);
    step();
    check_eq("bp_drain_occ", 32'(occupancy), 32'd0);
    $display("txn: backpressure T1/T2/T3 done");

    // Steady state: occupancy 1 with accept+release every cycle
    for (int i = 0; i < 6; i++) begin
      xa[i] = 8'(8'h13 * (i + 1));
      xb[i] = 8'(8'hC5 ^ (i * 8'h1B));
      xc[i] = i[0];
    end
    out_ready = 1'b0;
    offer(xa[0], xb[0], xc[0]);
    step();
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      offer(xa[i], xb[i], xc[i]);
      step();
      check_eq("ss_occ", 32'(occupancy), 32'd1);
      check_eq("ss_g", 32'(g), 32'(exp_g(xa[i], xb[i], xc[i])));
      check_eq("ss_p", 32'(p), 32'(exp_p(xa[i], xb[i])));
      $display("txn: steady a=%02h b=%02h cin=%0d g=%03h p=%03h", xa[i], xb[i], xc[i], g, p);
    end
    in_valid = 1'b0;
    step();
    check_eq("ss_drain_occ", 32'(occupancy), 32'd0);

    // Carry-out boundary vector, held under stall
    out_ready = 1'b0;
    offer(8'hFF, 8'h01, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("edge_valid", 32'(out_valid), 32'd1);
      check_eq("edge_g", 32'(g), 32'h002);
      check_eq("edge_p", 32'(p), 32'h1FC);
      step();
    end
    $display("txn: a=FF b=01 cin=0 held 3 cycles");

    // Fill, then asynchronous reset mid-cycle
    offer(8'h77, 8'h11, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("rst2_pre_occ", 32'(occupancy), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("rst2_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst2_occ", 32'(occupancy), 32'd0);
    check_eq("rst2_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst2_g", 32'(g), 32'd0);
    check_eq("rst2_p", 32'(p), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    offer(8'h0C, 8'h0A, 1'b0);
    step();
    in_valid = 1'b0;
    check_eq("rst2_post_occ", 32'(occupancy), 32'd1);
    check_eq("rst2_post_g", 32'(g), 32'h010);
    check_eq("rst2_post_p", 32'(p), 32'h00C);
    step();
    check_eq("rst2_no_stale", 32'(out_valid), 32'd0);
    $display("txn: async reset with full buffer done");

    // Random valid/ready against a queue scoreboard
    sb_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      @(negedge clk);
      check_eq("rnd_occ", 32'(occupancy), 32'(sb_q.size()));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("rnd_underflow", 32'd1, 32'd0);
        end else begin
          check_eq("rnd_g", 32'(g), 32'(sb_q[0].gv));
          check_eq("rnd_p", 32'(p), 32'(sb_q[0].pv));
          void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{gv: exp_g(a, b, cin), pv: exp_p(a, b)});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    $display("txn: random run finished, %0d entries left in scoreboard", sb_q.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
